zb_tiler_scan: RTL

Parametrised bounding-box rasteriser, successor to the first-generation tiler. It accepts one triangle (three vertices of x, y, z and luminance) and emits every covered screen pixel in raster order, with flat z and luminance taken from a selectable provoking vertex. It adds screen clipping, back/front-face culling, degenerate-triangle rejection and valid/ready back-pressure on the pixel output. It sits between the triangle source and the z-buffer compare/write stage.

---
 rtl/zb_tiler_scan_if.sv | 27 ++
 rtl/zb_tiler_scan.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/zb_tiler_scan_if.sv
// Triangle-in / pixel-out handshake bundle for the bounding-box rasteriser.
// The slave side is the rasteriser; the master side is the triangle source and pixel consumer.
interface zb_tiler_scan_if #(
    parameter int N = 9
);
    logic              load;
    logic              load_ready;
    logic [3:0][N-1:0] A;
    logic [3:0][N-1:0] B;
    logic [3:0][N-1:0] C;
    logic [1:0]        prov_sel;
    logic [1:0]        cull_mode;
    logic [3:0][N-1:0] pixel;
    logic              pixel_out;
    logic              pixel_ready;
    logic              fin_calcul;

    modport master (
        output load, A, B, C, prov_sel, cull_mode, pixel_ready,
        input  load_ready, pixel, pixel_out, fin_calcul
    );

    modport slave (
        input  load, A, B, C, prov_sel, cull_mode, pixel_ready,
        output load_ready, pixel, pixel_out, fin_calcul
    );
endinterface

// File: rtl/zb_tiler_scan.sv
// Bounding-box triangle rasteriser: clips, culls and rejects degenerate triangles, then
// scans the box in raster order emitting covered pixels with flat z/lum from a provoking vertex.
module zb_tiler_scan #(
    parameter int N    = 9,
    parameter int XMAX = 320,
    parameter int YMAX = 240
) (
    input  logic           clk,
    input  logic           reset,
    zb_tiler_scan_if.slave bus
);
    localparam int           EW   = 2*N + 3;
    localparam logic [N-1:0] XLIM = N'(XMAX - 1);
    localparam logic [N-1:0] YLIM = N'(YMAX - 1);
    localparam logic [N-1:0] ONE  = N'(1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0][N-1:0] r_a, r_b, r_c;
    logic [1:0]        r_prov, r_cull;
    logic [N-1:0]      r_xmin, r_xmax, r_ymax, r_cx, r_cy;
    logic              r_neg;
    logic [3:0][N-1:0] r_pix;
    logic              r_pix_vld;

    logic [N-1:0]         w_xmin, w_xmax_raw, w_ymin, w_ymax_raw, w_pz, w_pl;
    logic signed [EW-1:0] w_area, w_e_ab, w_e_bc, w_e_ca;
    logic                 w_area_zero, w_reject, w_inside, w_adv, w_last;

    function automatic logic signed [EW-1:0] edge_fn(
        input logic [N-1:0] ux, uy, vx, vy, px, py);
        logic signed [EW-1:0] dvx, dvy, dpx, dpy;
        dvx = $signed(EW'(vx)) - $signed(EW'(ux));
        dvy = $signed(EW'(vy)) - $signed(EW'(uy));
        dpx = $signed(EW'(px)) - $signed(EW'(ux));
        dpy = $signed(EW'(py)) - $signed(EW'(uy));
        return dvx*dpy - dvy*dpx;
    endfunction

    // Edge test oriented by the winding: pixels on the edge count as inside.
    function automatic logic side_ok(input logic signed [EW-1:0] e, input logic neg);
        return neg ? (e[EW-1] || (e == '0)) : !e[EW-1];
    endfunction

    function automatic logic [N-1:0] min3(input logic [N-1:0] a, b, c);
        logic [N-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [N-1:0] max3(input logic [N-1:0] a, b, c);
        logic [N-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign w_xmin      = min3(r_a[0], r_b[0], r_c[0]);
    assign w_xmax_raw  = max3(r_a[0], r_b[0], r_c[0]);
    assign w_ymin      = min3(r_a[1], r_b[1], r_c[1]);
    assign w_ymax_raw  = max3(r_a[1], r_b[1], r_c[1]);
    assign w_area      = edge_fn(r_a[0], r_a[1], r_b[0], r_b[1], r_c[0], r_c[1]);
    assign w_area_zero = (w_area == '0);
    assign w_reject    = (w_xmin > XLIM) || (w_ymin > YLIM) || w_area_zero
                      || ((r_cull == 2'd1) && w_area[EW-1])
                      || ((r_cull == 2'd2) && !w_area[EW-1] && !w_area_zero);

    assign w_e_ab   = edge_fn(r_a[0], r_a[1], r_b[0], r_b[1], r_cx, r_cy);
    assign w_e_bc   = edge_fn(r_b[0], r_b[1], r_c[0], r_c[1], r_cx, r_cy);
    assign w_e_ca   = edge_fn(r_c[0], r_c[1], r_a[0], r_a[1], r_cx, r_cy);
    assign w_inside = side_ok(w_e_ab, r_neg) && side_ok(w_e_bc, r_neg) && side_ok(w_e_ca, r_neg);

    assign w_pz = (r_prov == 2'd1) ? r_b[2] : (r_prov == 2'd2) ? r_c[2] : r_a[2];
    assign w_pl = (r_prov == 2'd1) ? r_b[3] : (r_prov == 2'd2) ? r_c[3] : r_a[3];

    // The scan advances only when the output register can take a new value.
    assign w_adv  = !r_pix_vld || bus.pixel_ready;
    assign w_last = (r_cx == r_xmax) && (r_cy == r_ymax);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (bus.load) w_next = SETUP;
            SETUP: w_next = w_reject ? DONE : SCAN;
            SCAN:  if (w_adv && w_last) w_next = DONE;
            DONE:  if (w_adv) w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.fin_calcul = 1'b0;
        if (!reset) begin
            bus.load_ready = (r_state == IDLE);
            bus.fin_calcul = (r_state == DONE) && w_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.load) begin
            r_a    <= bus.A;
            r_b    <= bus.B;
            r_c    <= bus.C;
            r_prov <= bus.prov_sel;
            r_cull <= bus.cull_mode;
        end
        if (r_state == SETUP) begin
            r_xmin <= w_xmin;
            r_xmax <= (w_xmax_raw > XLIM) ? XLIM : w_xmax_raw;
            r_ymax <= (w_ymax_raw > YLIM) ? YLIM : w_ymax_raw;
            r_cx   <= w_xmin;
            r_cy   <= w_ymin;
            r_neg  <= w_area[EW-1];
        end else if (r_state == SCAN && w_adv) begin
            if (r_cx == r_xmax) begin
                r_cx <= r_xmin;
                r_cy <= r_cy + ONE;
            end else begin
                r_cx <= r_cx + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_vld <= 1'b0;
            r_pix     <= '0;
        end else if (w_adv) begin
            r_pix_vld <= (r_state == SCAN) && w_inside;
            if (r_state == SCAN && w_inside) r_pix <= {w_pl, w_pz, r_cy, r_cx};
        end
    end

    assign bus.pixel     = r_pix;
    assign bus.pixel_out = r_pix_vld;
endmodule
